levinson_ke_step: RTL and testbench
===================================

Name: levinson_ke_step

Overview:
- Fixed-point, parametrised successor to the floating-point reflection-coefficient stage of the LPC (Levinson-Durbin) encoder path.
- Per order step m it computes k(m+1) = -alpha/E(m) and E(m+1) = E(m)*(1 - k^2).
- Uses a sequential restoring divider plus registered multiplies; no FP IP cores.
- Adds a valid/ready handshake, a pass-through order tag, saturation and zero-error detection, and an order-independent constant latency.

Parameters:
- DATA_W, 32, width of alpha, error and k words.
- FRAC_W, 30, fractional bits of k (Q(DATA_W-FRAC_W).FRAC_W); requires FRAC_W <= DATA_W-2.
- TAG_W, 5, width of the order tag carried with each transaction.

Ports:
- iClock  in  1  rising-edge clock.
- iReset_n  in  1  asynchronous, active-low reset.
- iValid  in  1  input transaction valid.
- oReady  out  1  block can accept input (high only in IDLE).
- iAlpha  in  DATA_W  signed alpha(m).
- iError  in  DATA_W  unsigned prediction error E(m).
- iTag  in  TAG_W  order index, returned unchanged.
- oValid  out  1  result valid; held until accepted.
- iReady  in  1  downstream accepts result.
- oK  out  DATA_W  signed k(m+1), FRAC_W fractional bits.
- oError  out  DATA_W  unsigned E(m+1).
- oTag  out  TAG_W  tag of this result.
- oSat  out  1  |alpha| >= E, so k was clamped.
- oZeroErr  out  1  E(m) was 0.

Behaviour:
- Reset (async assert, sync release): state IDLE; oValid, oK, oError, oTag, oSat, oZeroErr = 0; oReady = 1 once in IDLE.
- Reset mid-operation aborts the transaction; no partial result is ever presented.
- States: IDLE -> DIV -> SQ -> UPD -> DONE -> IDLE.
- IDLE: on iValid & oReady (edge T0):
  - capture |alpha|, sign, E and tag;
  - sat = (E != 0) & (|alpha| >= E);
  - zero = (E == 0);
  - remainder = |alpha|;
  - go to DIV.
- |alpha| is a DATA_W-bit unsigned value, so alpha = most-negative is valid.
- DIV: FRAC_W cycles, one quotient bit per cycle, MSB first:
  - rem = rem<<1;
  - if rem >= E then rem -= E and bit = 1.
  - Result is q = floor(|alpha| * 2^FRAC_W / E). Remainder width is DATA_W+1 bits.
- SQ (1 cycle):
  - if sat, q = 2^FRAC_W - 1;
  - if zero, q = 0;
  - k = (alpha negative) ? +q : -q;
  - ksq = (q*q) >> FRAC_W, truncating.
- UPD (1 cycle):
  - E' = (E * (2^FRAC_W - ksq)) >> FRAC_W, truncating; E' <= E always;
  - if zero, E' = 0;
  - load oK, oError, oTag, oSat, oZeroErr; oValid = 1; go to DONE.
- Latency: oValid rises at edge T0 + FRAC_W + 2 (32 cycles at default). The same latency applies for sat and zero.
- DONE:
  - outputs held stable while iValid is ignored and oReady = 0;
  - on oValid & iReady, oValid is cleared at that edge and the state goes to IDLE;
  - oK, oError, oTag, oSat and oZeroErr keep their values until the next UPD.
- Throughput: one transaction per FRAC_W + 4 cycles with no backpressure.
- iAlpha, iError and iTag are sampled only at the accept edge; changes afterwards have no effect.

Optional Feature:
- Macro: LEVINSON_KE_ROUND_EN.
- Defined:
  - DIV runs FRAC_W+1 iterations, and q is rounded half-up on the extra bit;
  - if q reaches 2^FRAC_W it clamps to 2^FRAC_W - 1, with oSat unchanged;
  - ksq and E' add 2^(FRAC_W-1) before the shift;
  - latency = FRAC_W + 3.
- Undefined: truncation throughout; latency = FRAC_W + 2.

Test Plan (DATA_W=32, FRAC_W=30, macro undefined):
- alpha=0x20000000, E=0x40000000, tag=3 -> after 32 cycles: oK=0xE0000000 (-0.5), oError=0x30000000, oTag=3, oSat=0, oZeroErr=0.
- alpha=-3, E=12 -> oK=0x10000000 (+0.25), oError=11 (12*15/16 truncated).
- alpha=100, E=50 -> oK=0xC0000001, oSat=1, oError=0, latency 32.
- alpha=5, E=0 -> oK=0, oError=0, oZeroErr=1, oSat=0, latency 32.
- Hold iReady=0 for 10 cycles after oValid -> outputs stable, oReady=0, toggled iValid/iAlpha ignored; iReady=1 -> oValid=0 next edge, oReady=1.
- Drive iReset_n low at cycle 10 of DIV -> outputs 0 immediately, no oValid; then alpha=0x20000000, E=0x40000000 -> oK=0xE0000000 after 32 cycles.

Source files
------------

// File: rtl/levinson_ke_step.sv
// levinson_ke_step: fixed-point Levinson-Durbin reflection step, k = -alpha/E and E' = E*(1-k^2).
// Optional macro LEVINSON_KE_ROUND_EN: round half-up quotient, ksq and E' (one extra divide cycle).
module levinson_ke_step #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 30,
  parameter int TAG_W  = 5
) (
  input  logic              iClock,
  input  logic              iReset_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iAlpha,
  input  logic [DATA_W-1:0] iError,
  input  logic [TAG_W-1:0]  iTag,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oK,
  output logic [DATA_W-1:0] oError,
  output logic [TAG_W-1:0]  oTag,
  output logic              oSat,
  output logic              oZeroErr
);
`ifdef LEVINSON_KE_ROUND_EN
  localparam int ITER = FRAC_W + 1;
  localparam int RND  = 1;
`else
  localparam int ITER = FRAC_W;
  localparam int RND  = 0;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam int SW = 2 * FRAC_W + 1;
  localparam int UW = DATA_W + FRAC_W + 1;
  localparam logic [SW-1:0] HALF_SQ = SW'(RND) << (FRAC_W - 1);
  localparam logic [UW-1:0] HALF_UP = UW'(RND) << (FRAC_W - 1);
  typedef enum logic [2:0] {IDLE, DIV, SQ, UPD, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W:0] rem, rem_sh, rem_nx;
  logic [ITER-1:0] quo;
  logic [DATA_W-1:0] e_r, alpha_abs, k_r, k_nx, e_new;
  logic [TAG_W-1:0] tag_r;
  logic neg, sat, zero, ge, accept, div_en, sq_en, upd_en;
  logic [FRAC_W-1:0] q_base, q_sel;
  logic [FRAC_W:0] ksq, ksq_nx, one_m;
  logic [SW-1:0] sq_full;
  logic [UW-1:0] upd_full;
  always_ff @(posedge iClock or negedge iReset_n)
    if (!iReset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = iValid ? DIV : IDLE;
      DIV:  state_nx = (cnt == CW'(ITER - 1)) ? SQ : DIV;
      SQ:   state_nx = UPD;
      UPD:  state_nx = DONE;
      DONE: state_nx = iReady ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    oReady = state == IDLE;
    accept = oReady & iValid;
    div_en = state == DIV;
    sq_en  = state == SQ;
    upd_en = state == UPD;
  end
  always_comb begin
    alpha_abs = iAlpha[DATA_W-1] ? -iAlpha : iAlpha;
    rem_sh    = rem << 1;
    ge        = rem_sh >= {1'b0, e_r};
    rem_nx    = ge ? rem_sh - {1'b0, e_r} : rem_sh;
`ifdef LEVINSON_KE_ROUND_EN
    q_base    = (&quo) ? {FRAC_W{1'b1}} : quo[ITER-1:1] + FRAC_W'(quo[0]);
`else
    q_base    = quo;
`endif
    q_sel     = zero ? '0 : sat ? {FRAC_W{1'b1}} : q_base;
    k_nx      = neg ? DATA_W'(q_sel) : -DATA_W'(q_sel);
    sq_full   = SW'(q_sel) * SW'(q_sel) + HALF_SQ;
    ksq_nx    = (FRAC_W + 1)'(sq_full >> FRAC_W);
    one_m     = {1'b1, {FRAC_W{1'b0}}} - ksq;
    upd_full  = UW'(e_r) * UW'(one_m) + HALF_UP;
    e_new     = DATA_W'(upd_full >> FRAC_W);
  end
  // Output registers only change in UPD, so they hold through DONE and IDLE.
  always_ff @(posedge iClock or negedge iReset_n)
    if (!iReset_n) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      e_r <= '0;
      neg <= 1'b0;
      sat <= 1'b0;
      zero <= 1'b0;
      tag_r <= '0;
      k_r <= '0;
      ksq <= '0;
      oValid <= 1'b0;
      oK <= '0;
      oError <= '0;
      oTag <= '0;
      oSat <= 1'b0;
      oZeroErr <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= '0;
        rem <= {1'b0, alpha_abs};
        quo <= '0;
        e_r <= iError;
        neg <= iAlpha[DATA_W-1];
        sat <= (iError != '0) & (alpha_abs >= iError);
        zero <= iError == '0;
        tag_r <= iTag;
      end
      if (div_en) begin
        cnt <= cnt + 1'b1;
        rem <= rem_nx;
        quo <= (quo << 1) | ITER'(ge);
      end
      if (sq_en) begin
        k_r <= k_nx;
        ksq <= ksq_nx;
      end
      if (upd_en) begin
        oK <= k_r;
        oError <= zero ? '0 : e_new;
        oTag <= tag_r;
        oSat <= sat;
        oZeroErr <= zero;
      end
      oValid <= upd_en | (oValid & ~iReady);
    end
endmodule

// File: tb/tb_levinson_ke_step.sv
// tb_levinson_ke_step: directed vectors with hand-computed results for the default truncating build.
module tb_levinson_ke_step;
  logic iClock, iReset_n, iValid, oReady, iReady, oValid, oSat, oZeroErr;
  logic [31:0] iAlpha, iError, oK, oError;
  logic [4:0] iTag, oTag;
  int vec = 0, bad = 0, lat, seen;
  logic [31:0] k_hold;
  levinson_ke_step dut (
    .iClock(iClock), .iReset_n(iReset_n), .iValid(iValid), .oReady(oReady),
    .iAlpha(iAlpha), .iError(iError), .iTag(iTag), .oValid(oValid), .iReady(iReady),
    .oK(oK), .oError(oError), .oTag(oTag), .oSat(oSat), .oZeroErr(oZeroErr)
  );
  initial iClock = 1'b0;
  always #5 iClock = ~iClock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] e, input logic [4:0] t, output int l);
    @(negedge iClock);
    iAlpha = a; iError = e; iTag = t; iValid = 1'b1;
    @(posedge iClock);
    #1 iValid = 1'b0; iAlpha = 32'h7fffffff; iError = 32'h1; iTag = 5'h1f;
    l = 0;
    while (l < 100) begin
      @(negedge iClock);
      if (oValid) break;
      l++;
    end
  endtask
  task automatic release_result;
    @(negedge iClock);
    iReady = 1'b1;
    @(posedge iClock);
    #1 iReady = 1'b0;
    chk("rel_valid", 64'(oValid), 64'd0);
    chk("rel_ready", 64'(oReady), 64'd1);
  endtask
  initial begin
    iReset_n = 1'b0; iValid = 1'b0; iReady = 1'b0; iAlpha = '0; iError = '0; iTag = '0;
    repeat (3) @(negedge iClock);
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_ready", 64'(oReady), 64'd1);
    chk("rst_k", 64'(oK), 64'd0);
    chk("rst_err", 64'(oError), 64'd0);
    chk("rst_flags", {oTag, oSat, oZeroErr}, 64'd0);
    iReset_n = 1'b1;
    run(32'h20000000, 32'h40000000, 5'd3, lat);
    chk("t1_lat", 64'(lat), 64'd32);
    chk("t1_k", 64'(oK), 64'hE0000000);
    chk("t1_err", 64'(oError), 64'h30000000);
    chk("t1_tag", 64'(oTag), 64'd3);
    chk("t1_flags", {oSat, oZeroErr}, 64'd0);
    chk("t1_busy", 64'(oReady), 64'd0);
    repeat (10) begin
      @(negedge iClock);
      iValid = ~iValid; iAlpha = $urandom; iError = $urandom;
    end
    iValid = 1'b0;
    @(negedge iClock);
    chk("bp_valid", 64'(oValid), 64'd1);
    chk("bp_ready", 64'(oReady), 64'd0);
    chk("bp_k", 64'(oK), 64'hE0000000);
    chk("bp_err", 64'(oError), 64'h30000000);
    release_result();
    run(-32'sd3, 32'd12, 5'd7, lat);
    chk("t2_lat", 64'(lat), 64'd32);
    chk("t2_k", 64'(oK), 64'h10000000);
    chk("t2_err", 64'(oError), 64'd11);
    chk("t2_tag", 64'(oTag), 64'd7);
    chk("t2_flags", {oSat, oZeroErr}, 64'd0);
    release_result();
    run(32'd100, 32'd50, 5'd9, lat);
    chk("t3_lat", 64'(lat), 64'd32);
    chk("t3_k", 64'(oK), 64'hC0000001);
    chk("t3_err", 64'(oError), 64'd0);
    chk("t3_flags", {oSat, oZeroErr}, 64'b10);
    release_result();
    run(32'd5, 32'd0, 5'd1, lat);
    chk("t4_lat", 64'(lat), 64'd32);
    chk("t4_k", 64'(oK), 64'd0);
    chk("t4_err", 64'(oError), 64'd0);
    chk("t4_flags", {oSat, oZeroErr}, 64'b01);
    release_result();
    run(32'h80000000, 32'hFFFFFFFF, 5'd30, lat);
    chk("t5_lat", 64'(lat), 64'd32);
    chk("t5_k", 64'(oK), 64'h20000000);
    chk("t5_err", 64'(oError), 64'hBFFFFFFF);
    chk("t5_tag", 64'(oTag), 64'd30);
    chk("t5_flags", {oSat, oZeroErr}, 64'd0);
    release_result();
    run(-32'sd50, 32'd50, 5'd2, lat);
    chk("t6_k", 64'(oK), 64'h3FFFFFFF);
    chk("t6_err", 64'(oError), 64'd0);
    chk("t6_flags", {oSat, oZeroErr}, 64'b10);
    release_result();
    k_hold = oK;
    chk("held_k", 64'(k_hold), 64'h3FFFFFFF);
    @(negedge iClock);
    iAlpha = 32'h20000000; iError = 32'h40000000; iTag = 5'd4; iValid = 1'b1;
    @(posedge iClock);
    #1 iValid = 1'b0;
    repeat (10) @(posedge iClock);
    #1 iReset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(oValid), 64'd0);
    chk("ar_k", 64'(oK), 64'd0);
    chk("ar_sat", 64'(oSat), 64'd0);
    chk("ar_ready", 64'(oReady), 64'd1);
    @(negedge iClock);
    iReset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge iClock);
      if (oValid) seen = 1;
    end
    chk("ar_no_partial", 64'(seen), 64'd0);
    run(32'h20000000, 32'h40000000, 5'd3, lat);
    chk("t7_lat", 64'(lat), 64'd32);
    chk("t7_k", 64'(oK), 64'hE0000000);
    chk("t7_err", 64'(oError), 64'h30000000);
    release_result();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
